// File: rtl/mc_request_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between requesters.
// Runs one transaction at a time with a fixed service window.
module mc_request_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MC_LATENCY = 4,
  parameter int AW         = 32,
  parameter int DW         = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  mc_enable,
  output logic                  mc_rw,
  output logic [AW-1:0]         mc_address,
  output logic [DW-1:0]         mc_data_in,
  input  logic [DW-1:0]         mc_data_out,
  output logic                  busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(MC_LATENCY - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          win_vld;
  logic [IW-1:0] win_idx;

  // Search upward from rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j       = 0;
    jj      = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j  = (int'(rr_q) + k) % NUM_REQ;
      jj = IW'(j);
      if (!win_vld && req_valid[jj]) begin
        win_vld = 1'b1;
        win_idx = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          rw_d    = req_rw[win_idx];
          addr_d  = req_addr[int'(win_idx)*AW +: AW];
          wdata_d = req_wdata[int'(win_idx)*DW +: DW];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (!rw_q) rdata_d = mc_data_out;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        rr_d    = (owner_q == LAST) ? '0 : owner_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Gated by reset_n so ready drops the instant reset asserts.
  assign req_ready  = (reset_n && state_q == S_IDLE && win_vld)
                    ? (NUM_REQ'(1) << win_idx) : '0;
  assign rsp_valid  = (state_q == S_RESP)
                    ? (NUM_REQ'(1) << owner_q) : '0;
  assign rsp_rdata  = rdata_q;
  assign mc_enable  = (state_q == S_ISSUE);
  assign mc_rw      = rw_q;
  assign mc_address = addr_q;
  assign mc_data_in = wdata_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mc_request_arbiter.sv
// Directed bench for mc_request_arbiter with a small controller memory model.
// Unwritten locations read back as addr[7:0] ^ 8'h5A.
module tb_mc_request_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 8;

  logic             clk;
  logic             reset_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_rw;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             mc_enable;
  logic             mc_rw;
  logic [AW-1:0]    mc_address;
  logic [DW-1:0]    mc_data_in;
  logic [DW-1:0]    mc_data_out;
  logic             busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [logic [31:0]];

  mc_request_arbiter #(
    .NUM_REQ(NR), .MC_LATENCY(4), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mc_enable(mc_enable),
    .mc_rw(mc_rw), .mc_address(mc_address),
    .mc_data_in(mc_data_in), .mc_data_out(mc_data_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mc_enable) begin
      if (mc_rw) mem[mc_address] = mc_data_in;
      else if (mem.exists(mc_address)) mc_data_out <= mem[mc_address];
      else mc_data_out <= mc_address[7:0] ^ 8'h5A;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the ISSUE cycle; counts edges until the response strobe.
  task automatic wait_rsp(input string tag, input int exp_cyc);
    int n;
    n = 0;
    while (rsp_valid == '0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(n), 64'(exp_cyc));
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic rw,
                         input logic [31:0] a, input logic [7:0] d);
    req_rw[i]           = rw;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] oh;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_rw      = '0;
    req_addr    = '0;
    req_wdata   = '0;
    mc_data_out = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_en", mc_enable, 0);
    chk("rst_rw", mc_rw, 0);
    chk("rst_addr", mc_address, 0);
    chk("rst_din", mc_data_in, 0);
    chk("rst_rdata", rsp_rdata, 0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // 1: single write from req0
    set_req(0, 1'b1, 32'h0000_4010, 8'hAA);
    req_valid = 4'b0001;
    #1 chk("t1_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    chk("t1_en", mc_enable, 1);
    chk("t1_addr", mc_address, 32'h4010);
    chk("t1_din", mc_data_in, 8'hAA);
    chk("t1_rw", mc_rw, 1);
    chk("t1_busy", busy, 1);
    cyc();
    chk("t1_en_off", mc_enable, 0);
    wait_rsp("t1_lat", 4);
    chk("t1_rsp", rsp_valid, 4'b0001);
    cyc();
    chk("t1_idle", busy, 0);
    chk("t1_rsp_off", rsp_valid, 0);
    chk("t1_hold_addr", mc_address, 32'h4010);

    // 2: read back from req0 (rr_ptr now 1, still only requester)
    set_req(0, 1'b0, 32'h0000_4010, 8'h00);
    req_valid = 4'b0001;
    #1 chk("t2_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    wait_rsp("t2_lat", 5);
    chk("t2_rsp", rsp_valid, 4'b0001);
    chk("t2_rdata", rsp_rdata, 8'hAA);
    cyc();

    // 3: contention from reset, req1 then req2
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    set_req(1, 1'b0, 32'h0000_1000, 8'h00);
    set_req(2, 1'b0, 32'h0000_8010, 8'h00);
    req_valid = 4'b0110;
    #1 chk("t3_ready1", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0100;
    chk("t3_ready_busy", req_ready, 0);
    wait_rsp("t3_lat1", 5);
    chk("t3_rsp1", rsp_valid, 4'b0010);
    chk("t3_rdata1", rsp_rdata, 8'h5A);
    cyc();
    chk("t3_ready2", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    wait_rsp("t3_lat2", 5);
    chk("t3_rsp2", rsp_valid, 4'b0100);
    chk("t3_rdata2", rsp_rdata, 8'h4A);
    cyc();

    // 4: all four valid continuously, from rr_ptr 0
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'(32'h100 * (i + 1)), 8'h00);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      oh = 4'(1 << (k % 4));
      #1 chk("t4_grant", req_ready, oh);
      cyc();
      wait_rsp("t4_lat", 5);
      chk("t4_rsp", rsp_valid, oh);
      cyc();
    end
    req_valid = '0;

    // 5: reset during WAIT (rr_ptr is 2 here)
    set_req(0, 1'b0, 32'h0000_4010, 8'h00);
    req_valid = 4'b0001;
    #1 chk("t5_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    reset_n   = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("t5_en", mc_enable, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rsp", rsp_valid, 0);
    chk("t5_ready", req_ready, 0);
    chk("t5_addr", mc_address, 0);
    chk("t5_rdata", rsp_rdata, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t5_rsp_hold", rsp_valid, 0);
    end
    reset_n = 1'b1;
    #1 chk("t5_rrptr0", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    wait_rsp("t5_lat", 5);
    chk("t5_rsp_ok", rsp_valid, 4'b0001);
    chk("t5_rdata_ok", rsp_rdata, 8'hAA);
    cyc();

    // 6: req3 pulses while busy, never granted
    set_req(1, 1'b1, 32'h0000_2000, 8'h33);
    req_valid = 4'b0010;
    #1 chk("t6_ready", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 4'b1000;
    #1 chk("t6_noready", req_ready, 0);
    cyc();
    req_valid = '0;
    wait_rsp("t6_lat", 3);
    chk("t6_rsp", rsp_valid, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t6_quiet_rsp", rsp_valid, 0);
      chk("t6_quiet_busy", busy, 0);
    end
    set_req(2, 1'b0, 32'h0000_2000, 8'h00);
    req_valid = 4'b0100;
    #1 chk("t6_ready2", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    wait_rsp("t6_lat2", 5);
    chk("t6_rsp2", rsp_valid, 4'b0100);
    chk("t6_rdata2", rsp_rdata, 8'h33);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
